// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing a multicycle RV32I datapath,
// with retired-instruction counting and illegal-opcode / memory-timeout traps.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  Opcode,
    input  logic [2:0]  Funct3,
    input  logic [6:0]  Funct7,
    input  logic        BranchTaken,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic [1:0]  PCSrc,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        RegWrite,
    output logic [1:0]  WBSel,
    output logic [3:0]  State,
    output logic        InstrRetired,
    output logic [31:0] InstrCount,
    output logic [1:0]  TrapCause
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
        MEM_WR = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7, ALU_WB = 4'd8, EXEC_BR = 4'd9,
        EXEC_JAL = 4'd10, EXEC_JALR = 4'd11, EXEC_U = 4'd12, TRAP = 4'd15
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic [1:0] next_cause;
    logic       mem_wait, retire, fetch_done, unused;

    // ALU function selection from funct fields happens in the ALU decoder, not here
    assign unused       = ^{Funct3, Funct7};
    assign mem_wait     = state == FETCH || state == MEM_RD || state == MEM_WR;
    assign retire       = !reset && next_state == FETCH && state != FETCH && state != TRAP;
    assign fetch_done   = MemReady && !reset;
    assign State        = state;
    assign InstrRetired = retire;

    always_comb begin
        next_state = state;
        next_cause = TrapCause;
        case (state)
            FETCH:    next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Opcode)
                    7'b0000011, 7'b0100011: next_state = MEM_ADDR;
                    7'b0110011:             next_state = EXEC_R;
                    7'b0010011:             next_state = EXEC_I;
                    7'b1100011:             next_state = EXEC_BR;
                    7'b1101111:             next_state = EXEC_JAL;
                    7'b1100111:             next_state = EXEC_JALR;
                    7'b0110111, 7'b0010111: next_state = EXEC_U;
                    default: begin
                        next_state = TRAP;
                        next_cause = 2'b01;
                    end
                endcase
            end
            MEM_ADDR: next_state = Opcode[5] ? MEM_WR : MEM_RD;
            MEM_RD:   next_state = MemReady ? MEM_WB : MEM_RD;
            MEM_WR:   next_state = MemReady ? FETCH : MEM_WR;
            EXEC_R, EXEC_I, EXEC_U: next_state = ALU_WB;
            MEM_WB, ALU_WB, EXEC_BR, EXEC_JAL, EXEC_JALR: next_state = FETCH;
            TRAP:     next_state = TRAP;
            default: begin
                next_state = TRAP;
                next_cause = 2'b01;
            end
        endcase
        // a late MemReady on the final wait cycle still completes the access
        if (mem_wait && !MemReady && wait_cnt == LAST_WAIT) begin
            next_state = TRAP;
            next_cause = 2'b10;
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 2'd0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrcA  = 2'd0;
        ALUSrcB  = 2'd0;
        ALUOp    = 2'd0;
        RegWrite = 1'b0;
        WBSel    = 2'd0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = fetch_done;
                PCWrite = fetch_done;
            end
            DECODE: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
            end
            MEM_ADDR: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                WBSel    = 2'd1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 2'd2;
                ALUOp   = 2'b10;
            end
            EXEC_I: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
                ALUOp   = 2'b11;
            end
            EXEC_U: begin
                ALUSrcA = Opcode[5] ? 2'd3 : 2'd1;
                ALUSrcB = 2'd2;
            end
            ALU_WB:   RegWrite = 1'b1;
            EXEC_BR: begin
                ALUSrcA = 2'd2;
                ALUOp   = 2'b01;
                PCWrite = BranchTaken;
                PCSrc   = 2'd1;
            end
            EXEC_JAL: begin
                RegWrite = 1'b1;
                WBSel    = 2'd2;
                PCWrite  = 1'b1;
                PCSrc    = 2'd1;
            end
            EXEC_JALR: begin
                ALUSrcA  = 2'd2;
                ALUSrcB  = 2'd2;
                RegWrite = 1'b1;
                WBSel    = 2'd2;
                PCWrite  = 1'b1;
                PCSrc    = 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            InstrCount <= 32'd0;
            TrapCause  <= 2'b00;
            wait_cnt   <= 8'd0;
        end else begin
            state     <= next_state;
            TrapCause <= next_cause;
            wait_cnt  <= (next_state != state) ? 8'd0 : wait_cnt + 8'(mem_wait && !MemReady);
            if (retire)
                InstrCount <= InstrCount + 32'd1;
        end
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the multicycle RV32I datapath.
- Decodes the latched instruction's opcode/funct fields and drives these control lines each cycle:
  - PC and IR write enables
  - memory request strobes
  - ALU operand and operation selects
  - register-file writeback
- The immediate generator and ALU stay combinational. This block decides when their outputs are captured.
- Also tracks retired instructions and raises traps for illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive cycles a memory state waits for MemReady before trapping. Allowed range 1..255; the wait counter is 8-bit.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Opcode  in  7  IR[6:0]
- Funct3  in  3  IR[14:12]
- Funct7  in  7  IR[31:25]
- BranchTaken  in  1  ALU compare result for the current branch funct3
- MemReady  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  load PC
- PCSrc  out  2  0 = ALUResult, 1 = ALUOut register, 2 = ALUResult & ~1
- IorD  out  1  0 = memory address from PC, 1 = from ALUOut
- IRWrite  out  1  latch instruction and OldPC
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- ALUSrcA  out  2  0 = PC, 1 = OldPC, 2 = rs1, 3 = zero
- ALUSrcB  out  2  0 = rs2, 1 = constant 4, 2 = ImmOut
- ALUOp  out  2  00 = add, 01 = branch compare (funct3), 10 = R-type (funct3/funct7), 11 = I-type (funct3)
- RegWrite  out  1  register-file write
- WBSel  out  2  0 = ALUOut, 1 = memory data register, 2 = PC
- State  out  4  current state, for debug and verification
- InstrRetired  out  1  one-cycle pulse on the final cycle of each instruction
- InstrCount  out  32  retired-instruction counter
- TrapCause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout

Behaviour:
- State encoding:

  | State | Code |
  |---|---|
  | FETCH | 0 |
  | DECODE | 1 |
  | MEM_ADDR | 2 |
  | MEM_RD | 3 |
  | MEM_WB | 4 |
  | MEM_WR | 5 |
  | EXEC_R | 6 |
  | EXEC_I | 7 |
  | ALU_WB | 8 |
  | EXEC_BR | 9 |
  | EXEC_JAL | 10 |
  | EXEC_JALR | 11 |
  | EXEC_U | 12 |
  | TRAP | 15 |

  Codes 13 and 14 are unused and go to TRAP with cause 01.
- Reset (asynchronous): State = FETCH, InstrCount = 0, TrapCause = 0, wait counter = 0.
- Outputs while in reset: MemRead = 1, ALUSrcA = 0, ALUSrcB = 1, ALUOp = 00, IorD = 0. All other strobes are 0.
- Reset asserted mid-instruction abandons that instruction; it is not counted.
- Outputs not listed for a state are 0.
- FETCH:
  - MemRead = 1, IorD = 0, ALU computes PC + 4.
  - When MemReady = 1 (Mealy): IRWrite = 1, PCWrite = 1 with PCSrc = 0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - ALUSrcA = 1, ALUSrcB = 2, ALUOp = 00; ALUOut captures OldPC + imm as the branch/JAL target.
  - Next state by opcode:

    | Opcode | Next state |
    |---|---|
    | 0000011, 0100011 | MEM_ADDR |
    | 0110011 | EXEC_R |
    | 0010011 | EXEC_I |
    | 1100011 | EXEC_BR |
    | 1101111 | EXEC_JAL |
    | 1100111 | EXEC_JALR |
    | 0110111, 0010111 | EXEC_U |
    | any other | TRAP, cause 01 |

- MEM_ADDR: ALUSrcA = 2, ALUSrcB = 2, ALUOp = 00. Next state MEM_RD for loads, MEM_WR for stores.
- MEM_RD: MemRead = 1, IorD = 1. Next state MEM_WB on MemReady.
- MEM_WB: RegWrite = 1, WBSel = 1, retire. Next state FETCH.
- MEM_WR: MemWrite = 1, IorD = 1. On MemReady: retire, next state FETCH.
- EXEC_R: ALUSrcA = 2, ALUSrcB = 0, ALUOp = 10. Next state ALU_WB.
- EXEC_I: ALUSrcA = 2, ALUSrcB = 2, ALUOp = 11. Next state ALU_WB.
- EXEC_U: ALUSrcB = 2, ALUOp = 00, ALUSrcA = 3 for LUI or 1 for AUIPC. Next state ALU_WB.
- ALU_WB: RegWrite = 1, WBSel = 0, retire. Next state FETCH.
- EXEC_BR: ALUSrcA = 2, ALUSrcB = 0, ALUOp = 01. PCWrite = BranchTaken with PCSrc = 1. Retire; next state FETCH.
- EXEC_JAL: RegWrite = 1, WBSel = 2 (PC already holds OldPC + 4). PCWrite = 1, PCSrc = 1. Retire; next state FETCH.
- EXEC_JALR:
  - ALUSrcA = 2, ALUSrcB = 2, ALUOp = 00.
  - RegWrite = 1, WBSel = 2, PCWrite = 1, PCSrc = 2.
  - The register file writes on the clock edge, so rs1 == rd reads the old value.
  - Retire; next state FETCH.
- Memory wait timeout (FETCH, MEM_RD, MEM_WR):
  - The wait counter increments each cycle with MemReady = 0 and clears on any state change.
  - When it reaches TIMEOUT_CYCLES with MemReady still 0: next state TRAP, TrapCause = 10.
  - MemReady arriving on that same cycle wins; no trap.
- TRAP: all strobes 0. TrapCause held. Exit only by reset.
- Retirement:
  - InstrRetired = 1 on the cycle that transitions to FETCH from any non-TRAP state.
  - InstrCount increments at that edge and wraps from FFFFFFFF to 0.
- Latency with MemReady always 1:

  | Instruction | Cycles |
  |---|---|
  | Branch, JAL, JALR | 3 |
  | R, I, U, store | 4 |
  | Load | 5 |

  Each memory wait cycle adds 1.

Test Plan:
1. ADDI (0x00500093), MemReady = 1 throughout -> State sequence 0, 1, 7, 8, 0.
   - IRWrite and PCWrite pulse in cycle 1.
   - RegWrite = 1 in ALU_WB.
   - InstrCount = 1 after 4 cycles.
2. LW, MemReady low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles.
   - MemRead = 1 and IorD = 1 throughout MEM_RD.
   - 8 cycles total.
   - RegWrite with WBSel = 1 exactly once.
3. BEQ with BranchTaken = 1, then 0 -> PCWrite = 1 with PCSrc = 1 in EXEC_BR for the first, PCWrite = 0 for the second.
   - Both retire after 3 cycles.
4. Opcode 0x7F -> DECODE goes to TRAP (State = 15), TrapCause = 01, all strobes 0.
   - Stays there until reset; reset returns State = 0 and TrapCause = 00.
5. TIMEOUT_CYCLES = 4, MemReady held 0 in FETCH -> TRAP after the 4th cycle with TrapCause = 10.
   - Rerun with MemReady = 1 on the 4th cycle -> DECODE, no trap.
6. JALR, then reset asserted in MEM_ADDR of a following SW -> JALR: PCWrite with PCSrc = 2 and RegWrite with WBSel = 2 in the same cycle.
   - Reset: State returns to 0 immediately (asynchronously), InstrCount returns to 0, no MemWrite issued.
